// File: rtl/out_fifo_pkg.sv
// Shared types and helpers for the buffered output channel.
package out_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } ser_state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;

    // Number of transmitter bytes making up one core word.
    function automatic int unsigned bytes_per_word(input int unsigned data_w,
                                                   input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    // Pointer width for a power-of-two FIFO; count needs one extra bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy count, registered full.
module sync_fifo
    import out_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned PTR_W = ptr_width(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q;
    logic              do_push, do_pop;

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    // Next occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, count and the registered full flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/out_fifo_serializer.sv
// Buffered word-to-byte output channel: FIFO of core words feeding a byte serializer.
// Optional feature macro: OUT_FIFO_LEVEL_EN adds the `level` occupancy port.
module out_fifo_serializer
    import out_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned MSB_FIRST = 1,
    localparam int unsigned NBYTES   = bytes_per_word(DATA_W, BYTE_W),
    localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1,
    localparam int unsigned CNT_W    = ptr_width(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              out_req,
    input  logic [DATA_W-1:0] out_data,
    output logic              out_busy,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              overflow,
`ifdef OUT_FIFO_LEVEL_EN
    output logic [CNT_W-1:0]  level,
`endif
    output logic              idle
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, fifo_pop;

    ser_state_t        state_q;
    logic [DATA_W-1:0] shreg_q, shreg_next;
    logic [BYTE_W-1:0] cur_byte;
    logic [IDX_W-1:0]  byte_idx_q;
    logic              guard_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic              overflow_q;

    assign fifo_pop = (state_q == S_IDLE) && !fifo_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (out_req),
        .wdata (out_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Current byte sits at the outgoing end of the shift register.
    always_comb begin
        if (MSB_FIRST != 0) begin
            cur_byte   = shreg_q[DATA_W-1 -: BYTE_W];
            shreg_next = shreg_q << BYTE_W;
        end else begin
            cur_byte   = shreg_q[BYTE_W-1:0];
            shreg_next = shreg_q >> BYTE_W;
        end
    end

    // Serializer FSM with registered transmitter outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            guard_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shreg_q    <= fifo_rdata;
                        byte_idx_q <= '0;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data_q  <= cur_byte;
                        tx_start_q <= 1'b1;
                        shreg_q    <= shreg_next;
                        guard_q    <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle gives the transmitter time to raise tx_busy.
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!tx_busy) begin
                        if (byte_idx_q == LAST_IDX) begin
                            state_q <= S_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                            state_q    <= S_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow: a push arriving while full is lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_q <= 1'b0;
        end else if (out_req && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_busy = fifo_full;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign overflow = overflow_q;
    assign idle     = (fifo_count == '0) && (state_q == S_IDLE) && !tx_busy;
`ifdef OUT_FIFO_LEVEL_EN
    assign level    = fifo_count;
`endif

endmodule

// File: tb/tb_out_fifo_serializer.sv
// Scoreboard bench: one MSB-first and one LSB-first instance share all stimulus.
module tb_out_fifo_serializer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              out_req = 1'b0;
    logic [DATA_W-1:0] out_data = '0;
    logic              tx_busy = 1'b0;

    logic              m_busy, m_start, m_ovf, m_idle;
    logic [BYTE_W-1:0] m_data;
    logic              l_busy, l_start, l_ovf, l_idle;
    logic [BYTE_W-1:0] l_data;
`ifdef OUT_FIFO_LEVEL_EN
    logic [CNT_W-1:0]  m_level, l_level;
`endif

    int checks = 0;
    int errors = 0;
    int bytes_seen = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    bit   busy_rand = 1'b0;
    logic busy_hold = 1'b0;
    logic m_prev = 1'b0;
    logic l_prev = 1'b0;

    always #5 clk = ~clk;

    out_fifo_serializer #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .MSB_FIRST(1)
    ) u_msb (
        .clk(clk), .rstn(rstn), .out_req(out_req), .out_data(out_data),
        .out_busy(m_busy), .tx_data(m_data), .tx_start(m_start), .tx_busy(tx_busy),
        .overflow(m_ovf),
`ifdef OUT_FIFO_LEVEL_EN
        .level(m_level),
`endif
        .idle(m_idle)
    );

    out_fifo_serializer #(
        .DATA_W(DATA_W), .BYTE_W(BYTE_W), .DEPTH(DEPTH), .MSB_FIRST(0)
    ) u_lsb (
        .clk(clk), .rstn(rstn), .out_req(out_req), .out_data(out_data),
        .out_busy(l_busy), .tx_data(l_data), .tx_start(l_start), .tx_busy(tx_busy),
        .overflow(l_ovf),
`ifdef OUT_FIFO_LEVEL_EN
        .level(l_level),
`endif
        .idle(l_idle)
    );

    // Transmitter busy model: held level or random per cycle.
    always @(negedge clk) tx_busy = busy_rand ? 1'($urandom_range(0, 1)) : busy_hold;

    // Output monitor: pop the scoreboard on every transmit strobe.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rstn) begin
            m_prev = 1'b0;
            l_prev = 1'b0;
        end else begin
            if (m_start) begin
                bytes_seen++;
                checks++;
                if (m_prev) begin
                    errors++;
                    $display("FAIL msb_start_consecutive: tx_start high two cycles");
                end
                checks++;
                if (exp_m.size() == 0) begin
                    errors++;
                    $display("FAIL msb_unexpected_byte: got %h, required none", m_data);
                end else begin
                    e = exp_m.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL msb_byte: got %h, required %h", m_data, e);
                    end
                end
            end
            if (l_start) begin
                checks++;
                if (l_prev) begin
                    errors++;
                    $display("FAIL lsb_start_consecutive: tx_start high two cycles");
                end
                checks++;
                if (exp_l.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_unexpected_byte: got %h, required none", l_data);
                end else begin
                    e = exp_l.pop_front();
                    if (l_data !== e) begin
                        errors++;
                        $display("FAIL lsb_byte: got %h, required %h", l_data, e);
                    end
                end
            end
            m_prev = m_start;
            l_prev = l_start;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k, input bit msb);
        return msb ? w[31-8*k -: 8] : w[8*k +: 8];
    endfunction

    task automatic push_expect(input logic [31:0] w, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            exp_m.push_back(exp_byte(w, k, 1'b1));
            exp_l.push_back(exp_byte(w, k, 1'b0));
        end
    endtask

    // Present a word at the negedge; it is sampled at the following posedge.
    task automatic drive_push(input logic [31:0] w);
        @(negedge clk);
        out_req  = 1'b1;
        out_data = w;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn      = 1'b0;
        out_req   = 1'b0;
        out_data  = '0;
        busy_rand = 1'b0;
        busy_hold = 1'b0;
        repeat (2) @(negedge clk);
        exp_m.delete();
        exp_l.delete();
        rstn = 1'b1;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((exp_m.size() != 0 || exp_l.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d/%0d bytes outstanding, required 0",
                     name, exp_m.size(), exp_l.size());
        end
        busy_rand = 1'b0;
        busy_hold = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (m_idle !== 1'b1 || l_idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle: got %b/%b, required 1/1", name, m_idle, l_idle);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #13;
        checks++;
        if (m_busy !== 1'b0 || m_start !== 1'b0 || m_data !== 8'h00 || m_ovf !== 1'b0 ||
            l_busy !== 1'b0 || l_start !== 1'b0 || l_data !== 8'h00 || l_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy %b/%b start %b/%b data %h/%h ovf %b/%b, required 0",
                     m_busy, l_busy, m_start, l_start, m_data, l_data, m_ovf, l_ovf);
        end
        checks++;
        if (m_idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b, required 1", m_idle);
        end
`ifdef OUT_FIFO_LEVEL_EN
        checks++;
        if (m_level !== '0) begin
            errors++;
            $display("FAIL reset_level: got %0d, required 0", m_level);
        end
`endif
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        push_expect(32'h11223344, 4);
        drive_push(32'h11223344);              // E0
        @(negedge clk);
        out_req = 1'b0;
        @(posedge clk);                        // E1
        #1;
        checks++;
        if (m_start !== 1'b0 || l_start !== 1'b0) begin
            errors++;
            $display("FAIL single_early_start: got %b/%b, required 0/0", m_start, l_start);
        end
        @(posedge clk);                        // E2
        #1;
        checks++;
        if (m_start !== 1'b1 || l_start !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: tx_start got %b/%b, required 1/1", m_start, l_start);
        end
        drain(200, "single");
    endtask

    task automatic test_overflow();
        apply_reset();
        busy_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            logic [31:0] w;
            w = 32'hA000_0000 + 32'(i);
            if (i < 17) push_expect(w, 4);
            drive_push(w);
            if (i == 15) begin
                checks++;
                if (m_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_busy_early: got %b, required 0", m_busy);
                end
            end
            if (i == 16) begin
                checks++;
                if (m_busy !== 1'b1 || l_busy !== 1'b1 || m_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: busy %b/%b ovf %b, required 1/1 0",
                             m_busy, l_busy, m_ovf);
                end
            end
            if (i == 17) begin
                checks++;
                if (m_ovf !== 1'b1 || l_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set: got %b/%b, required 1/1", m_ovf, l_ovf);
                end
            end
        end
        @(negedge clk);
        out_req = 1'b0;
        busy_hold = 1'b0;
        drain(3000, "ovf");
        checks++;
        if (m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", m_ovf);
        end
        apply_reset();
        #1;
        checks++;
        if (m_ovf !== 1'b0 || l_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got %b/%b, required 0/0", m_ovf, l_ovf);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        busy_rand = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            int n = 0;
            @(negedge clk);
            out_req = 1'b0;
            while (m_busy && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                checks++;
                errors++;
                $display("FAIL wrap_stall_timeout: out_busy stuck at word %0d", i);
            end
            push_expect(32'(i), 4);
            out_req  = 1'b1;
            out_data = 32'(i);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_req = 1'b0;
        drain(8000, "wrap");
        checks++;
        if (m_ovf !== 1'b0 || l_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_overflow: got %b/%b, required 0/0", m_ovf, l_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int b0;
        apply_reset();
        push_expect(32'hA1B2C3D4, 2);
        drive_push(32'hA1B2C3D4);              // E0
        drive_push(32'h0BAD0001);              // E1, first word popped
        drive_push(32'h0BAD0002);              // E2, byte 0 strobed
        drive_push(32'h0BAD0003);              // E3
        @(negedge clk);
        out_req = 1'b0;
        @(posedge clk);                        // E4
        @(posedge clk);                        // E5, byte 1 strobed
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (m_start !== 1'b0 || l_start !== 1'b0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: start %b/%b busy %b, required 0/0 0",
                     m_start, l_start, m_busy);
        end
`ifdef OUT_FIFO_LEVEL_EN
        checks++;
        if (m_level !== '0) begin
            errors++;
            $display("FAIL midrst_level: got %0d, required 0", m_level);
        end
`endif
        checks++;
        if (exp_m.size() != 0 || exp_l.size() != 0) begin
            errors++;
            $display("FAIL midrst_bytes_before: %0d/%0d outstanding, required 0",
                     exp_m.size(), exp_l.size());
        end
        b0 = bytes_seen;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (bytes_seen != b0 || m_idle !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: %0d extra bytes idle %b, required 0 and 1",
                     bytes_seen - b0, m_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] exp_lvl [3];
        exp_lvl[0] = CNT_W'(1);
        exp_lvl[1] = CNT_W'(1);
        exp_lvl[2] = CNT_W'(2);
        apply_reset();
        busy_hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push_expect(32'hCAFE0001 + 32'(i), 4);
            drive_push(32'hCAFE0001 + 32'(i));
            checks++;
            if (m_busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy_%0d: got %b, required 0", i, m_busy);
            end
`ifdef OUT_FIFO_LEVEL_EN
            checks++;
            if (m_level !== exp_lvl[i] || l_level !== exp_lvl[i]) begin
                errors++;
                $display("FAIL b2b_level_%0d: got %0d/%0d, required %0d",
                         i, m_level, l_level, exp_lvl[i]);
            end
`endif
        end
        @(negedge clk);
        out_req = 1'b0;
        busy_hold = 1'b0;
        drain(500, "b2b");
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
